// File: rtl/bictr_dcnto_ctrl.sv
// Command controller for the dynamic count-to up/down counter.
// Loads, runs to target, and cross-checks the counter against a shadow.
module bictr_dcnto_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             cmd_dir,
  input  logic             cmd_repeat,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] ctr_data,
  output logic             ctr_up_dn,
  output logic             ctr_load,
  output logic             ctr_cen,
  output logic [WIDTH-1:0] ctr_count_to,
  input  logic [WIDTH-1:0] ctr_count,
  input  logic             ctr_tercnt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   steps,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  localparam logic [WIDTH:0] LAST = {1'b0, {WIDTH{1'b1}}};

  state_t state, state_nxt;

  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH:0]   steps_q;
  logic             dir_q;
  logic             rpt_q;
  logic             err_q;
  logic             accept;
  logic             run_en;
  logic             ovf;

  assign accept = cmd_valid & cmd_ready;
  assign run_en = (state == RUN) & ctr_cen;
  // a full wrap without tercnt means the target is unreachable
  assign ovf    = run_en & (steps_q == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (ctr_tercnt || ovf) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = rpt_q ? LOAD : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // up_dn stays low in LOAD: the counter only loads with up_dn low
  always_comb begin
    cmd_ready = 1'b0;
    ctr_load  = 1'b0;
    ctr_cen   = 1'b0;
    ctr_up_dn = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: cmd_ready = 1'b1;
      LOAD: begin
        ctr_load = ~abort;
        ctr_cen  = ~abort;
      end
      RUN: begin
        ctr_up_dn = dir_q;
        ctr_cen   = ~abort & ~pause & ~ctr_tercnt;
      end
      DONE: done = ~abort;
      default: cmd_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      start_q  <= '0;
      target_q <= '0;
      dir_q    <= 1'b0;
      rpt_q    <= 1'b0;
      shadow_q <= '0;
      steps_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        start_q  <= cmd_start;
        target_q <= cmd_target;
        dir_q    <= cmd_dir;
        rpt_q    <= cmd_repeat;
        err_q    <= 1'b0;
      end
      if (state == LOAD && !abort) begin
        shadow_q <= start_q;
        steps_q  <= '0;
      end
      if (state == RUN) begin
        if (ctr_count != shadow_q) err_q <= 1'b1;
        if (ovf) err_q <= 1'b1;
      end
      if (run_en) begin
        shadow_q <= dir_q ? shadow_q + 1'b1 : shadow_q - 1'b1;
        steps_q  <= steps_q + 1'b1;
      end
    end
  end

  assign ctr_data     = start_q;
  assign ctr_count_to = target_q;
  assign busy         = (state != IDLE);
  assign steps        = steps_q;
  assign err          = err_q;

endmodule

// File: tb/tb_bictr_dcnto_ctrl.sv
// Bench for bictr_dcnto_ctrl with a behavioural count-to counter attached.
// Vector table, random runs and hand sequences for pause/abort/repeat/faults.
module tb_bictr_dcnto_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_start = '0;
  logic [W-1:0] cmd_target = '0;
  logic         cmd_dir = 1'b0;
  logic         cmd_repeat = 1'b0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] ctr_data;
  logic         ctr_up_dn;
  logic         ctr_load;
  logic         ctr_cen;
  logic [W-1:0] ctr_count_to;
  logic [W-1:0] ctr_count;
  logic         ctr_tercnt;
  logic         busy;
  logic         done;
  logic [W:0]   steps;
  logic         err;

  int total = 0;
  int bad = 0;
  int n;

  logic         f_skip = 1'b0;
  logic         f_notc = 1'b0;
  logic [W-1:0] cnt;

  always #5 clk = ~clk;

  bictr_dcnto_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_start(cmd_start),
    .cmd_target(cmd_target),
    .cmd_dir(cmd_dir),
    .cmd_repeat(cmd_repeat),
    .pause(pause),
    .abort(abort),
    .ctr_data(ctr_data),
    .ctr_up_dn(ctr_up_dn),
    .ctr_load(ctr_load),
    .ctr_cen(ctr_cen),
    .ctr_count_to(ctr_count_to),
    .ctr_count(ctr_count),
    .ctr_tercnt(ctr_tercnt),
    .busy(busy),
    .done(done),
    .steps(steps),
    .err(err)
  );

  // counter model; f_skip makes it jump by 2, f_notc hides tercnt
  always @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (ctr_load && !ctr_up_dn) begin
      cnt <= ctr_data;
    end else if (ctr_cen) begin
      if (ctr_up_dn) cnt <= cnt + (f_skip ? 4'd2 : 4'd1);
      else cnt <= cnt - (f_skip ? 4'd2 : 4'd1);
    end
  end

  assign ctr_count  = cnt;
  assign ctr_tercnt = f_notc ? 1'b0 : (cnt == ctr_count_to);

  typedef struct {
    string    nm;
    logic [3:0] s;
    logic [3:0] t;
    logic     d;
    int       st;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] s, input logic [3:0] t,
                      input logic d, input logic r);
    @(negedge clk);
    cmd_start  = s;
    cmd_target = t;
    cmd_dir    = d;
    cmd_repeat = r;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
    n = 0;
  endtask

  task automatic wait_done(input int limit);
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_vec(input string nm, input logic [3:0] s,
                         input logic [3:0] t, input logic d, input int st);
    send(s, t, d, 1'b0);
    chk({nm, " load"}, ctr_load, 1);
    chk({nm, " load_updn"}, ctr_up_dn, 0);
    chk({nm, " load_cen"}, ctr_cen, 1);
    chk({nm, " data"}, ctr_data, s);
    chk({nm, " count_to"}, ctr_count_to, t);
    chk({nm, " ready_busy"}, cmd_ready, 0);
    @(negedge clk);
    n = 1;
    chk({nm, " first_count"}, ctr_count, s);
    chk({nm, " run_updn"}, ctr_up_dn, d);
    chk({nm, " first_cen"}, ctr_cen, (st != 0) ? 1 : 0);
    wait_done(60);
    chk({nm, " latency"}, n, st + 2);
    chk({nm, " steps"}, steps, st);
    chk({nm, " err"}, err, 0);
    chk({nm, " hold"}, ctr_count, t);
    @(negedge clk);
    chk({nm, " done_1cyc"}, done, 0);
    chk({nm, " ready_back"}, cmd_ready, 1);
  endtask

  logic [3:0] rs;
  logic [3:0] rt;
  logic       rd;
  int         re;

  initial begin
    vecs[0] = '{"up3to7", 4'd3, 4'd7, 1'b1, 4};
    vecs[1] = '{"dn1to14", 4'd1, 4'd14, 1'b0, 3};
    vecs[2] = '{"eq9", 4'd9, 4'd9, 1'b1, 0};
    vecs[3] = '{"up14to2", 4'd14, 4'd2, 1'b1, 4};
    vecs[4] = '{"dn0to15", 4'd0, 4'd15, 1'b0, 1};
    vecs[5] = '{"up15to0", 4'd15, 4'd0, 1'b1, 1};
    vecs[6] = '{"up5to4", 4'd5, 4'd4, 1'b1, 15};

    repeat (2) @(negedge clk);
    chk("rst ready", cmd_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst load", ctr_load, 0);
    chk("rst cen", ctr_cen, 0);
    chk("rst updn", ctr_up_dn, 0);
    chk("rst data", ctr_data, 0);
    chk("rst count_to", ctr_count_to, 0);
    chk("rst steps", steps, 0);
    chk("rst err", err, 0);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i].nm, vecs[i].s, vecs[i].t, vecs[i].d, vecs[i].st);
    end

    for (int i = 0; i < 20; i++) begin
      rs = 4'($urandom_range(0, 15));
      rt = 4'($urandom_range(0, 15));
      rd = 1'($urandom_range(0, 1));
      re = rd ? ((int'(rt) - int'(rs)) & 15) : ((int'(rs) - int'(rt)) & 15);
      run_vec("rand", rs, rt, rd, re);
    end

    send(4'd0, 4'd5, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    n = 3;
    chk("pause at2", ctr_count, 2);
    pause = 1'b1;
    #1;
    chk("pause cen", ctr_cen, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n++;
      chk("pause hold", ctr_count, 2);
    end
    pause = 1'b0;
    wait_done(60);
    chk("pause latency", n, 10);
    chk("pause steps", steps, 5);
    chk("pause err", err, 0);
    @(negedge clk);

    send(4'd0, 4'd10, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("abort at4", ctr_count, 4);
    abort = 1'b1;
    #1;
    chk("abort cen", ctr_cen, 0);
    chk("abort load", ctr_load, 0);
    @(negedge clk);
    abort = 1'b0;
    chk("abort ready", cmd_ready, 1);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort steps", steps, 4);
    repeat (3) @(negedge clk);
    chk("abort count", ctr_count, 4);

    send(4'd2, 4'd4, 1'b1, 1'b1);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      n++;
      chk("rpt done", done, (i >= 4 && (i - 4) % 5 == 0) ? 1 : 0);
      chk("rpt load", ctr_load, (i % 5 == 0) ? 1 : 0);
    end
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("rpt abort_load", ctr_load, 0);
    @(negedge clk);
    abort = 1'b0;
    chk("rpt abort_ready", cmd_ready, 1);

    f_skip = 1'b1;
    send(4'd0, 4'd6, 1'b1, 1'b0);
    wait_done(60);
    chk("skip done", done, 1);
    chk("skip err", err, 1);
    f_skip = 1'b0;
    repeat (3) @(negedge clk);
    chk("skip sticky", err, 1);
    send(4'd3, 4'd7, 1'b1, 1'b0);
    chk("skip clear", err, 0);
    wait_done(60);
    chk("clean err", err, 0);
    chk("clean steps", steps, 4);
    @(negedge clk);

    f_notc = 1'b1;
    send(4'd3, 4'd5, 1'b1, 1'b0);
    wait_done(60);
    chk("notc latency", n, 17);
    chk("notc steps", steps, 16);
    chk("notc err", err, 1);
    f_notc = 1'b0;
    @(negedge clk);

    send(4'd0, 4'd9, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("mrst cen_pre", ctr_cen, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst cen", ctr_cen, 0);
    chk("mrst load", ctr_load, 0);
    chk("mrst ready", cmd_ready, 1);
    chk("mrst steps", steps, 0);
    chk("mrst data", ctr_data, 0);
    reset = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bictr_dcnto_ctrl.md
Name: bictr_dcnto_ctrl

Overview:
Command-side controller for the dynamic count-to up/down counter. It accepts a start/target/direction command over a valid/ready handshake and drives the counter's data, load, cen, up_dn and count_to inputs. It watches the counter's count and tercnt to stop exactly on target, and reports done, the number of steps taken and an error flag. It checks the counter against an internal shadow count, so it also serves as a run-time monitor of the counter.

Parameters:
WIDTH, 4, counter width; sets the width of all data, target and count buses.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous reset, active low.
cmd_valid  input  1  command present.
cmd_ready  output  1  high only in IDLE.
cmd_start  input  WIDTH  value to load into the counter.
cmd_target  input  WIDTH  terminal value, driven onto count_to.
cmd_dir  input  1  1 = count up, 0 = count down.
cmd_repeat  input  1  1 = reload and rerun after each completion until abort.
pause  input  1  holds the counter in RUN (cen = 0).
abort  input  1  returns to IDLE from any state.
ctr_data  output  WIDTH  counter data input (latched cmd_start).
ctr_up_dn  output  1  counter direction.
ctr_load  output  1  counter load.
ctr_cen  output  1  counter enable.
ctr_count_to  output  WIDTH  latched cmd_target.
ctr_count  input  WIDTH  counter count.
ctr_tercnt  input  1  counter terminal flag (count == count_to).
busy  output  1  state is not IDLE.
done  output  1  one-cycle pulse on completion.
steps  output  WIDTH+1  number of enabled count cycles in the last or current run.
err  output  1  sticky until the next accepted command.

Behaviour:
- Reset (reset = 0 at a clk edge): state goes to IDLE. All outputs are 0, except cmd_ready = 1. Latched start, target, dir, repeat, steps, shadow and err are all cleared. Reset in mid-run drops ctr_cen and ctr_load in the next cycle.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: cmd_ready = 1, ctr_cen = 0, ctr_load = 0. On cmd_valid & cmd_ready, latch start/target/dir/repeat, clear err, and go to LOAD.
- LOAD: lasts exactly one cycle. Drives ctr_load = 1, ctr_cen = 1, ctr_up_dn = 0; ctr_up_dn must be 0 because the counter only loads when up_dn is low. Sets shadow = start and steps = 0, then goes to RUN.
- RUN:
  - ctr_up_dn = dir.
  - ctr_cen = ~pause & ~ctr_tercnt. This is combinational on tercnt, so the counter halts holding the target value.
  - Each cycle with ctr_cen = 1: shadow advances ±1 modulo 2^WIDTH and steps increments.
  - ctr_tercnt = 1 → go to DONE.
  - Every RUN cycle, ctr_count != shadow sets err.
  - steps reaching 2^WIDTH without tercnt sets err and goes to DONE.
- DONE: done = 1 for one cycle, ctr_cen = 0. Then go to IDLE, or to LOAD if repeat = 1.
- Latency: command accepted at edge N; load at edge N+1; first RUN cycle sees count = start.
- start == target: the first RUN cycle sees tercnt, so steps = 0 and done rises on the next cycle.
- Wrap-around: modulo 2^WIDTH arithmetic. For example, up from 14 to 2 takes 4 steps: 15, 0, 1, 2.
- Priority: reset > abort > tercnt > pause.
  - abort in LOAD, RUN or DONE: next state IDLE, ctr_load = ctr_cen = 0 in the abort cycle, no done pulse, steps retained.
  - abort and tercnt in the same cycle: abort wins and no done is issued.
  - pause has no effect in LOAD or DONE.
- cmd_valid outside IDLE is ignored; cmd_ready = 0.
- ctr_data and ctr_count_to hold their latched values until the next accepted command.

Test Plan:
- Up run: start = 3, target = 7, dir = 1, with a behavioural counter model → count 3, 4, 5, 6, 7; done pulses one cycle later; steps = 4; err = 0; count holds at 7.
- Down run with wrap: start = 1, target = 14, dir = 0 → 1, 0, 15, 14; steps = 3; ctr_up_dn = 0 throughout LOAD.
- start == target = 9 → steps = 0; done in the cycle after the first RUN cycle; ctr_cen = 0 in RUN.
- Pause: start = 0, target = 5, pause held for 3 RUN cycles at count = 2 → ctr_cen = 0 and count stays at 2; total steps = 5.
- Abort mid-run at count = 4, then repeat mode (start = 2, target = 4) → abort: IDLE next cycle, no done, cmd_ready = 1. Repeat: done pulses every 5 cycles, with LOAD reissued each time.
- Fault injection: the counter model skips a value (+2) → err = 1 sticky; it clears only on the next accepted command. A model that never asserts tercnt → err = 1 and done at steps = 16.
